dm_responder: RTL

//   Data-memory responder for the pipeline's load/store port. It accepts one word

---
 rtl/dm_responder.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/dm_responder.sv
// dm_responder: multi-cycle data-memory target for the MEM-stage load/store port.
// Accepts one word request at a time, spends LATENCY cycles busy, then holds a
// registered response (read data / merged store word plus error flag) until consumed.
module dm_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // Busy countdown starts at LATENCY-1 so the access executes on the last busy cycle.
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Byte-lane merge of store data over the current word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [ADDR_WIDTH-1:0] idx_s;
  logic                  err_s;
  logic [31:0]           cur_word_s;
  logic [31:0]           merged_s;
  logic                  mem_we_s;
  logic [31:0]           mem_rd_s [DEPTH];

  assign idx_s      = addr_q[ADDR_WIDTH+1:2];
  // Misaligned, or any word-address bit above the memory depth is set.
  assign err_s      = (addr_q[1:0] != 2'b00) || (|addr_q[31:ADDR_WIDTH+2]);
  assign cur_word_s = mem_rd_s[idx_s];
  assign merged_s   = merge_bytes(cur_word_s, wdata_q, be_q);
  // A store commits only on the execute cycle, so a reset while busy discards it.
  assign mem_we_s   = (state_q == ST_BUSY) && (cnt_q == 4'd0) && we_q && !err_s;

  // Memory words: each cleared by reset, written only by a committing store.
  for (genvar g = 0; g < DEPTH; g++) begin : g_mem
    logic [31:0] word_q;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        word_q <= 32'h0000_0000;
      end else if (mem_we_s && (idx_s == ADDR_WIDTH'(g))) begin
        word_q <= merged_s;
      end else begin
        word_q <= word_q;
      end
    end
    assign mem_rd_s[g] = word_q;
  end

  // Next-state and next-output computation for the IDLE/BUSY/RESP handshake FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid) begin
          we_d        = req_we;
          addr_d      = req_addr;
          be_d        = req_be;
          wdata_d     = req_wdata;
          cnt_d       = CNT_INIT;
          req_ready_d = 1'b0;
          state_d     = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        req_ready_d = 1'b0;
        if (cnt_q == 4'd0) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_s;
          if (err_s) begin
            rsp_rdata_d = 32'h0000_0000;
          end else if (we_q) begin
            rsp_rdata_d = merged_s;
          end else begin
            rsp_rdata_d = cur_word_s;
          end
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          req_ready_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // State, captured request and registered response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0000_0000;
      be_q        <= 4'h0;
      wdata_q     <= 32'h0000_0000;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
